// File: rtl/piano_voice_scheduler_pkg.sv
// piano_pkg: shared constants, scanner state type and the note half-period table
// for the switch-piano voice scheduler.
//   NUM_KEYS_DEF   default number of key inputs
//   KEY_IDX_W      width of a key index
//   CNT_W          width of a voice half-period counter
//   SAMPLE_W       width of a mixed audio sample
package piano_pkg;

    localparam int unsigned NUM_KEYS_DEF = 10;
    localparam int unsigned KEY_IDX_W    = 4;
    localparam int unsigned CNT_W        = 17;
    localparam int unsigned SAMPLE_W     = 32;

    // The scanner has a single operating state; kept as an enum so more can be added.
    typedef enum logic [0:0] {
        ST_SCAN = 1'b0
    } scan_state_t;

    // Half period minus one, in 50 MHz cycles, for C4 D4 E4 F4 G4 A4 B4 C5 D5 E5.
    function automatic logic [CNT_W-1:0] half_period_m1(input logic [KEY_IDX_W-1:0] key);
        logic [CNT_W-1:0] hp;
        case (key)
            4'd0:    hp = 17'd95554;
            4'd1:    hp = 17'd85130;
            4'd2:    hp = 17'd75842;
            4'd3:    hp = 17'd71586;
            4'd4:    hp = 17'd63774;
            4'd5:    hp = 17'd56817;
            4'd6:    hp = 17'd50619;
            4'd7:    hp = 17'd47777;
            4'd8:    hp = 17'd42564;
            4'd9:    hp = 17'd37920;
            default: hp = 17'd95554;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/piano_voice_scheduler_if.sv
// Audio output handshake between the voice scheduler and Audio_Controller.
//   audio_out_allowed        output FIFO has space (from Audio_Controller)
//   write_audio_out          write strobe (to Audio_Controller)
//   left/right_channel_...   signed sample data, valid while write_audio_out is high
interface piano_voice_scheduler_if;
    import piano_pkg::*;

    logic                audio_out_allowed;
    logic                write_audio_out;
    logic [SAMPLE_W-1:0] left_channel_audio_out;
    logic [SAMPLE_W-1:0] right_channel_audio_out;

    modport master (
        input  audio_out_allowed,
        output write_audio_out,
        output left_channel_audio_out,
        output right_channel_audio_out
    );

    modport slave (
        output audio_out_allowed,
        input  write_audio_out,
        input  left_channel_audio_out,
        input  right_channel_audio_out
    );
endinterface

// File: rtl/piano_voice_scheduler_tone_voice.sv
// tone_voice: one square-wave voice. Holds its key, a half-period counter and the
// output phase (0 = positive half, 1 = negative half).
//   clk, rst    clock, synchronous active-high reset
//   i_alloc     claim this voice for i_key, restart at the positive half
//   i_free      release this voice
//   i_key       key index latched on allocation
//   o_active    voice is sounding
//   o_key       key owned by this voice
//   o_phase     current square-wave half
module tone_voice
    import piano_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_alloc,
    input  logic                 i_free,
    input  logic [KEY_IDX_W-1:0] i_key,
    output logic                 o_active,
    output logic [KEY_IDX_W-1:0] o_key,
    output logic                 o_phase
);

    logic                 r_active;
    logic [KEY_IDX_W-1:0] r_key;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_phase;
    logic [CNT_W-1:0]     w_hp_m1;

    assign w_hp_m1 = half_period_m1(r_key);

    // Allocation and release both restart the waveform at the positive half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_key    <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (i_alloc) begin
            r_active <= 1'b1;
            r_key    <= i_key;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (i_free) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (r_active) begin
            if (r_cnt == w_hp_m1) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_active = r_active;
    assign o_key    = r_key;
    assign o_phase  = r_phase;

endmodule

// File: rtl/piano_voice_scheduler.sv
// piano_voice_scheduler: scans the keys one per cycle, hands held keys to the
// lowest free square-wave voice, frees voices of released keys, and mixes the
// active voices into a registered sample for Audio_Controller.
//   CLOCK_50      50 MHz clock
//   reset         synchronous active-high reset
//   key_on        held keys, bit k = key k
//   audio_if      audio output handshake (master side)
//   voice_active  voice v is sounding
//   voice_key     key index of voice v in bits [4v+3:4v]
//   dropped       one-cycle pulse: a held key found no free voice
module piano_voice_scheduler
    import piano_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF,
    parameter int unsigned NUM_VOICES = 4,
    parameter logic [31:0] AMPLITUDE  = 32'd10000000
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic [NUM_KEYS-1:0]             key_on,
    piano_voice_scheduler_if.master         audio_if,
    output logic [NUM_VOICES-1:0]           voice_active,
    output logic [KEY_IDX_W*NUM_VOICES-1:0] voice_key,
    output logic                            dropped
);

    scan_state_t                r_state;
    logic [KEY_IDX_W-1:0]       r_scan_idx;
    logic                       r_dropped;
    logic signed [SAMPLE_W-1:0] r_sample;

    logic [NUM_VOICES-1:0]      w_active;
    logic [NUM_VOICES-1:0]      w_phase;
    logic [KEY_IDX_W-1:0]       w_vkey [NUM_VOICES];
    logic [NUM_VOICES-1:0]      w_hit;
    logic [NUM_VOICES-1:0]      w_alloc;
    logic [NUM_VOICES-1:0]      w_free;
    logic                       w_key_cur;
    logic                       w_assigned;
    logic                       w_want_alloc;
    logic                       w_any_free;
    logic signed [SAMPLE_W-1:0] w_mix;

    // Decode the visited key and which voice (if any) already owns it.
    always_comb begin
        w_key_cur = 1'b0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (r_scan_idx == KEY_IDX_W'(k)) begin
                w_key_cur = key_on[k];
            end
        end
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            w_hit[v] = w_active[v] && (w_vkey[v] == r_scan_idx);
        end
        w_assigned   = |w_hit;
        w_want_alloc = w_key_cur && !w_assigned;
        w_free       = w_key_cur ? '0 : w_hit;
    end

    // Lowest-numbered free voice takes the visited key.
    always_comb begin
        w_alloc    = '0;
        w_any_free = 1'b0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (!w_active[v] && !w_any_free) begin
                w_alloc[v] = w_want_alloc;
                w_any_free = 1'b1;
            end
        end
    end

    // Mix: each active voice contributes +/-AMPLITUDE depending on its phase.
    always_comb begin
        w_mix = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (w_active[v]) begin
                w_mix = w_phase[v] ? (w_mix - $signed(AMPLITUDE))
                                   : (w_mix + $signed(AMPLITUDE));
            end
        end
    end

    // Scanner, drop flag and sample register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= ST_SCAN;
            r_scan_idx <= '0;
            r_dropped  <= 1'b0;
            r_sample   <= '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_scan_idx == KEY_IDX_W'(NUM_KEYS - 1)) begin
                        r_scan_idx <= '0;
                    end else begin
                        r_scan_idx <= r_scan_idx + KEY_IDX_W'(1);
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
            r_dropped <= w_want_alloc && !w_any_free;
            r_sample  <= w_mix;
        end
    end

    for (genvar v = 0; v < int'(NUM_VOICES); v++) begin : g_voice
        tone_voice u_voice (
            .clk      (CLOCK_50),
            .rst      (reset),
            .i_alloc  (w_alloc[v]),
            .i_free   (w_free[v]),
            .i_key    (r_scan_idx),
            .o_active (w_active[v]),
            .o_key    (w_vkey[v]),
            .o_phase  (w_phase[v])
        );
        assign voice_key[KEY_IDX_W*v +: KEY_IDX_W] = w_vkey[v];
    end

    assign voice_active                     = w_active;
    assign dropped                          = r_dropped;
    assign audio_if.write_audio_out         = audio_if.audio_out_allowed & ~reset;
    assign audio_if.left_channel_audio_out  = r_sample;
    assign audio_if.right_channel_audio_out = r_sample;

endmodule
